counter: RTL and testbench



---
 rtl/counter_pkg.sv | 24 ++
 rtl/counter.sv | 93 +++++++++
 tb/tb_counter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter block.
//   DEFAULT_MAX_COUNT    : default terminal value (10 = 4'b1010).
//   counter_params_valid : elaboration-time legality check for the counter
//                          parameters. It returns 1 only when
//                          0 < max_count <= 2**width-1 and
//                          0 <= reset_value <= max_count.
package counter_pkg;

  localparam int DEFAULT_MAX_COUNT = 10;

  function automatic bit counter_params_valid(input int width,
                                              input int max_count,
                                              input int reset_value);
    longint limit;
    // The width bound keeps the shift below inside a signed 64-bit value.
    if (width < 1 || width > 62) begin
      return 1'b0;
    end
    limit = (longint'(1) << width) - longint'(1);
    return (max_count > 0) && (longint'(max_count) <= limit) &&
           (reset_value >= 0) && (reset_value <= max_count);
  endfunction

endpackage

// File: rtl/counter.sv
// Parameterised synchronous up-counter with terminal-count flags.
// Counts up by one per clock from RESET_VALUE to MAX_COUNT. At MAX_COUNT it
// either holds (SATURATE=1) or wraps to 0 (SATURATE=0).
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous, active-high reset (has priority over counting)
//   count       : registered counter value
//   at_max      : high while count == MAX_COUNT (decoded from the register)
//   reached_max : one-cycle pulse in the cycle count first becomes MAX_COUNT
//   wrapped     : one-cycle pulse in the cycle after MAX_COUNT -> 0
//                 (always 0 when SATURATE=1)
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter bit SATURATE    = 1'b1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             reached_max,
  output logic             wrapped
);

  // Refuse to build with parameters that would make the counter overflow
  // or start above its terminal value.
  generate
    if (!counter_params_valid(WIDTH, MAX_COUNT, RESET_VALUE)) begin : g_param_check
      $fatal(1, "counter: illegal WIDTH/MAX_COUNT/RESET_VALUE combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL     = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] PRE_MAX_VAL = WIDTH'(MAX_COUNT - 1);
  localparam logic [WIDTH-1:0] RST_VAL     = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             reached_max_reg;
  logic             reached_max_next;
  logic             wrapped_reg;
  logic             wrapped_next;

  always_comb begin
    count_next       = count_reg;
    reached_max_next = 1'b0;
    wrapped_next     = 1'b0;
    if (count_reg == MAX_VAL) begin
      // Saturate mode leaves count_next at its hold value.
      if (!SATURATE) begin
        count_next   = '0;
        wrapped_next = 1'b1;
      end
    end else begin
      // count_reg < MAX_COUNT <= 2**WIDTH-1, so this never overflows.
      count_next       = count_reg + WIDTH'(1);
      // Only the MAX_COUNT-1 -> MAX_COUNT step raises the pulse, so holding
      // at the terminal value never retriggers it.
      reached_max_next = (count_reg == PRE_MAX_VAL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg       <= RST_VAL;
      reached_max_reg <= 1'b0;
      wrapped_reg     <= 1'b0;
    end else begin
      count_reg       <= count_next;
      reached_max_reg <= reached_max_next;
      wrapped_reg     <= wrapped_next;
    end
  end

  assign count       = count_reg;
  assign at_max      = (count_reg == MAX_VAL);
  assign reached_max = reached_max_reg;
  assign wrapped     = wrapped_reg;

  // Sanity properties on the running counter.
  a_count_in_range : assert property (@(posedge clk) disable iff (reset)
    count_reg <= MAX_VAL);

  a_saturate_holds : assert property (@(posedge clk) disable iff (reset)
    (SATURATE && at_max) |=> $stable(count_reg));

  a_reached_single : assert property (@(posedge clk) disable iff (reset)
    reached_max_reg |=> !reached_max_reg);

endmodule

// File: tb/tb_counter.sv
// Bench for counter: four instances share one clock and one reset stream.
//   u_sat  : defaults (WIDTH=4, MAX_COUNT=10, saturate, RESET_VALUE=0),
//            checked against a hand-written table of expected values.
//   u_wrap : MAX_COUNT=10, wrap mode.
//   u_full : MAX_COUNT=15, wrap mode (full 4-bit range).
//   u_rvm  : saturate, RESET_VALUE=MAX_COUNT=10.
// Expectations for every instance are pushed to queues when reset is driven
// and popped/compared one time unit after the following rising edge.
module tb_counter;
  import counter_pkg::*;

  typedef struct {
    logic       rst;
    logic [3:0] cnt;
    logic       am;
    logic       rm;
    logic       wr;
  } vec_t;

  typedef struct {
    logic [3:0] cnt;
    logic       am;
    logic       rm;
    logic       wr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [3:0] cnt_sat, cnt_wrap, cnt_full, cnt_rvm;
  logic am_sat, am_wrap, am_full, am_rvm;
  logic rm_sat, rm_wrap, rm_full, rm_rvm;
  logic wr_sat, wr_wrap, wr_full, wr_rvm;

  int checks = 0;
  int errors = 0;

  vec_t tbl[64];
  int   n_vec = 0;

  exp_t q_sat[$], q_wrap[$], q_full[$], q_rvm[$];

  always #5 clk = ~clk;

  counter #(.WIDTH(4), .MAX_COUNT(10), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
    .clk(clk), .reset(reset), .count(cnt_sat), .at_max(am_sat),
    .reached_max(rm_sat), .wrapped(wr_sat));

  counter #(.WIDTH(4), .MAX_COUNT(10), .SATURATE(1'b0), .RESET_VALUE(0)) u_wrap (
    .clk(clk), .reset(reset), .count(cnt_wrap), .at_max(am_wrap),
    .reached_max(rm_wrap), .wrapped(wr_wrap));

  counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1'b0), .RESET_VALUE(0)) u_full (
    .clk(clk), .reset(reset), .count(cnt_full), .at_max(am_full),
    .reached_max(rm_full), .wrapped(wr_full));

  counter #(.WIDTH(4), .MAX_COUNT(10), .SATURATE(1'b1), .RESET_VALUE(10)) u_rvm (
    .clk(clk), .reset(reset), .count(cnt_rvm), .at_max(am_rvm),
    .reached_max(rm_rvm), .wrapped(wr_rvm));

  task automatic add(input logic rst, input int c, input logic a,
                     input logic r, input logic w);
    tbl[n_vec].rst = rst;
    tbl[n_vec].cnt = 4'(c);
    tbl[n_vec].am  = a;
    tbl[n_vec].rm  = r;
    tbl[n_vec].wr  = w;
    n_vec++;
  endtask

  task automatic check(input string name, input int step, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, req);
    end
  endtask

  // Reference behaviour written from the block description.
  function automatic exp_t model_step(input exp_t cur, input logic rst,
                                      input int maxc, input bit sat, input int rv);
    exp_t nx;
    nx.rm = 1'b0;
    nx.wr = 1'b0;
    if (rst) begin
      nx.cnt = 4'(rv);
    end else if (int'(cur.cnt) < maxc) begin
      nx.cnt = cur.cnt + 4'd1;
      nx.rm  = (int'(nx.cnt) == maxc);
    end else if (sat) begin
      nx.cnt = cur.cnt;
    end else begin
      nx.cnt = 4'd0;
      nx.wr  = 1'b1;
    end
    nx.am = (int'(nx.cnt) == maxc);
    return nx;
  endfunction

  task automatic compare(input string tag, input int step, input exp_t e,
                         input logic [3:0] c, input logic a, input logic r, input logic w);
    check({tag, ".count"}, step, int'(c), int'(e.cnt));
    check({tag, ".at_max"}, step, int'(a), int'(e.am));
    check({tag, ".reached_max"}, step, int'(r), int'(e.rm));
    check({tag, ".wrapped"}, step, int'(w), int'(e.wr));
  endtask

  initial begin
    exp_t m_wrap, m_full, m_rvm, e;
    int   err_before;

    // Table: reset stream plus the expected outputs of the default instance.
    add(1'b1, 0, 1'b0, 1'b0, 1'b0);                        // reset -> 0
    for (int k = 1; k <= 9; k++) add(1'b0, k, 1'b0, 1'b0, 1'b0);
    add(1'b0, 10, 1'b1, 1'b1, 1'b0);                       // terminal, pulse
    for (int k = 0; k < 5; k++) add(1'b0, 10, 1'b1, 1'b0, 1'b0); // saturated
    add(1'b1, 0, 1'b0, 1'b0, 1'b0);                        // reset while saturated
    for (int k = 1; k <= 6; k++) add(1'b0, k, 1'b0, 1'b0, 1'b0);
    add(1'b1, 0, 1'b0, 1'b0, 1'b0);                        // mid-count reset at 6
    for (int k = 1; k <= 9; k++) add(1'b0, k, 1'b0, 1'b0, 1'b0);
    add(1'b0, 10, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) add(1'b0, 10, 1'b1, 1'b0, 1'b0);

    m_wrap = '{cnt: 4'd0, am: 1'b0, rm: 1'b0, wr: 1'b0};
    m_full = m_wrap;
    m_rvm  = m_wrap;

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      q_sat.push_back('{cnt: tbl[i].cnt, am: tbl[i].am, rm: tbl[i].rm, wr: tbl[i].wr});
      m_wrap = model_step(m_wrap, tbl[i].rst, 10, 1'b0, 0);
      m_full = model_step(m_full, tbl[i].rst, 15, 1'b0, 0);
      m_rvm  = model_step(m_rvm,  tbl[i].rst, 10, 1'b1, 10);
      q_wrap.push_back(m_wrap);
      q_full.push_back(m_full);
      q_rvm.push_back(m_rvm);

      @(posedge clk);
      #1;
      err_before = errors;
      e = q_sat.pop_front();
      compare("sat", i, e, cnt_sat, am_sat, rm_sat, wr_sat);
      e = q_wrap.pop_front();
      compare("wrap", i, e, cnt_wrap, am_wrap, rm_wrap, wr_wrap);
      e = q_full.pop_front();
      compare("full", i, e, cnt_full, am_full, rm_full, wr_full);
      e = q_rvm.pop_front();
      compare("rvmax", i, e, cnt_rvm, am_rvm, rm_rvm, wr_rvm);
      $display("step %0d reset=%0b sat=%0d wrap=%0d full=%0d rvmax=%0d %s",
               i, tbl[i].rst, cnt_sat, cnt_wrap, cnt_full, cnt_rvm,
               (errors == err_before) ? "ok" : "bad");
    end

    // Hand-written sequence: wrap-mode lap from a fresh reset, 0..10,0,1.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("lap.reset_count", 0, int'(cnt_wrap), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check("lap.count", k, int'(cnt_wrap), (k <= 10) ? k : k - 11);
      check("lap.wrapped", k, int'(wr_wrap), (k == 11) ? 1 : 0);
      check("lap.reached", k, int'(rm_wrap), (k == 10) ? 1 : 0);
      check("lap.full_count", k, int'(cnt_full), k);
      $display("lap step %0d wrap=%0d wrapped=%0b reached=%0b",
               k, cnt_wrap, wr_wrap, rm_wrap);
    end

    // Parameter legality: an illegal MAX_COUNT must be rejected.
    check("params.max16", 0, int'(counter_params_valid(4, 16, 0)), 0);
    check("params.max0", 0, int'(counter_params_valid(4, 0, 0)), 0);
    check("params.rv_above", 0, int'(counter_params_valid(4, 10, 11)), 0);
    check("params.max15", 0, int'(counter_params_valid(4, 15, 0)), 1);
    check("params.default", 0, int'(counter_params_valid(4, DEFAULT_MAX_COUNT, 0)), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
